// File: rtl/text_term_ctrl_pkg.sv
// Shared constants and state encoding for the text terminal write-side sequencer.
// Also used by the scanout through term_row_map.
package text_term_pkg;
    localparam int COLS    = 70;
    localparam int ROWS    = 30;
    localparam int COL_W   = 7;
    localparam int ROW_W   = 5;
    localparam int VMEM_AW = 12;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
endpackage

// File: rtl/text_term_ctrl_if.sv
// Keyboard byte handshake plus the vmem write port of the terminal sequencer.
interface text_term_ctrl_if;
    import text_term_pkg::*;

    logic               ch_valid;
    logic [7:0]         ch_data;
    logic               ch_ready;
    logic               vm_we;
    logic [VMEM_AW-1:0] vm_waddr;
    logic [7:0]         vm_wdata;

    modport master (output ch_valid, ch_data, input ch_ready, vm_we, vm_waddr, vm_wdata);
    modport slave  (input ch_valid, ch_data, output ch_ready, vm_we, vm_waddr, vm_wdata);
endinterface

// File: rtl/text_term_ctrl_row_map.sv
// Maps a logical screen row onto the ring-buffered physical vmem row.
module term_row_map
    import text_term_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    input  logic [ROW_W-1:0] top,
    output logic [ROW_W-1:0] phys
);
    logic [ROW_W:0] sum;

    always_comb begin
        sum  = {1'b0, row} + {1'b0, top};
        phys = (sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(sum - (ROW_W+1)'(ROWS)) : sum[ROW_W-1:0];
    end
endmodule

// File: rtl/text_term_ctrl.sv
// Write-side sequencer for the 70x30 character vmem: cursor tracking, control
// codes, line wrap and ring-buffer scrolling with a single-line clear.
module text_term_ctrl
    import text_term_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    text_term_ctrl_if.slave   bus,
    input  logic              clear_req,
    output logic [ROW_W-1:0]  top_row,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);
    localparam logic [COL_W-1:0] ONE_C    = COL_W'(1);
    localparam logic [ROW_W-1:0] ONE_R    = ROW_W'(1);

    state_t               state, state_n;
    logic [ROW_W-1:0]     top_n, row_n, line_row, line_n, clr_row, clr_row_n;
    logic [COL_W-1:0]     col_n, clr_col, clr_col_n;
    logic                 we_q, we_n;
    logic [VMEM_AW-1:0]   waddr_q, waddr_n;
    logic [7:0]           wdata_q, wdata_n;
    logic [ROW_W-1:0]     map_row, map_phys;
    logic                 printable, bs_up;

    assign printable = (bus.ch_data >= 8'h20) && (bus.ch_data <= 8'h7E);
    // Backspace from column 0 writes on the previous row, so map that row instead
    assign bs_up     = (bus.ch_data == BS) && (cursor_col == '0) && (cursor_row != '0);
    assign map_row   = bs_up ? cursor_row - ONE_R : cursor_row;

    term_row_map u_map (.row(map_row), .top(top_row), .phys(map_phys));

    assign bus.ch_ready = (state == IDLE) && !clear_req;
    assign bus.vm_we    = we_q;
    assign bus.vm_waddr = waddr_q;
    assign bus.vm_wdata = wdata_q;
    assign busy         = (state != IDLE);

    always_comb begin
        state_n   = state;
        top_n     = top_row;
        row_n     = cursor_row;
        col_n     = cursor_col;
        line_n    = line_row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        we_n      = 1'b0;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        case (state)
            CLR_ALL: begin
                if (clr_row == ROW_END) begin
                    state_n = IDLE;
                    top_n   = '0;
                    row_n   = '0;
                    col_n   = '0;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = {clr_col, clr_row};
                    wdata_n = BLANK;
                    if (clr_col == LAST_COL) begin
                        clr_col_n = '0;
                        clr_row_n = clr_row + ONE_R;
                    end else begin
                        clr_col_n = clr_col + ONE_C;
                    end
                end
            end
            CLR_LINE: begin
                if (clr_col == COL_END) begin
                    state_n = IDLE;
                end else begin
                    we_n      = 1'b1;
                    waddr_n   = {clr_col, line_row};
                    wdata_n   = BLANK;
                    clr_col_n = clr_col + ONE_C;
                end
            end
            default: begin
                if (clear_req) begin
                    // First blank is issued right away so the burst starts next cycle
                    state_n   = CLR_ALL;
                    we_n      = 1'b1;
                    waddr_n   = '0;
                    wdata_n   = BLANK;
                    clr_col_n = ONE_C;
                    clr_row_n = '0;
                end else if (bus.ch_valid) begin
                    if (printable) begin
                        we_n    = 1'b1;
                        waddr_n = {cursor_col, map_phys};
                        wdata_n = bus.ch_data;
                        if (cursor_col == LAST_COL) begin
                            col_n = '0;
                            if (cursor_row == LAST_ROW) begin
                                state_n   = CLR_LINE;
                                top_n     = (top_row == LAST_ROW) ? '0 : top_row + ONE_R;
                                line_n    = top_row;
                                clr_col_n = '0;
                            end else begin
                                row_n = cursor_row + ONE_R;
                            end
                        end else begin
                            col_n = cursor_col + ONE_C;
                        end
                    end else if (bus.ch_data == LF) begin
                        col_n = '0;
                        if (cursor_row == LAST_ROW) begin
                            // The old top row becomes the new bottom; clear it starting now
                            state_n   = CLR_LINE;
                            top_n     = (top_row == LAST_ROW) ? '0 : top_row + ONE_R;
                            line_n    = top_row;
                            we_n      = 1'b1;
                            waddr_n   = {{COL_W{1'b0}}, top_row};
                            wdata_n   = BLANK;
                            clr_col_n = ONE_C;
                        end else begin
                            row_n = cursor_row + ONE_R;
                        end
                    end else if (bus.ch_data == CR) begin
                        col_n = '0;
                    end else if (bus.ch_data == BS) begin
                        if (cursor_col != '0) begin
                            col_n   = cursor_col - ONE_C;
                            we_n    = 1'b1;
                            waddr_n = {cursor_col - ONE_C, map_phys};
                            wdata_n = BLANK;
                        end else if (bs_up) begin
                            row_n   = cursor_row - ONE_R;
                            col_n   = LAST_COL;
                            we_n    = 1'b1;
                            waddr_n = {LAST_COL, map_phys};
                            wdata_n = BLANK;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLR_ALL;
            top_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            line_row   <= '0;
            clr_col    <= '0;
            clr_row    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_n;
            top_row    <= top_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            line_row   <= line_n;
            clr_col    <= clr_col_n;
            clr_row    <= clr_row_n;
            we_q       <= we_n;
            waddr_q    <= waddr_n;
            wdata_q    <= wdata_n;
        end
    end
endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
- Write-side sequencer for the 70x30 character vmem that the VGA text scanout reads.
- Accepts ASCII bytes from the keyboard path over a valid/ready handshake and tracks the cursor.
- Issues single-port vmem writes and handles newline, CR, backspace, line wrap and scrolling.
- Scrolling uses a ring-buffer row offset (top_row) exported to the scanout, so a scroll costs only one 70-cycle line clear.

Parameters:
- COLS, 70, characters per row
- ROWS, 30, visible rows
- COL_W, 7, column index width
- ROW_W, 5, row index width (vmem row stride is 32)
- BLANK, 8'h20, fill character used for clears and backspace

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ch_valid  in  1  ASCII byte offered
- ch_data  in  8  ASCII byte
- ch_ready  out  1  byte accepted when ch_valid && ch_ready
- clear_req  in  1  level request: clear screen and home the cursor
- vm_we  out  1  vmem write strobe, one cell per cycle
- vm_waddr  out  12  {col[6:0], phys_row[4:0]}, column-priority vmem address
- vm_wdata  out  8  character to write
- top_row  out  5  physical vmem row shown as screen row 0; scanout uses phys = (screen_row + top_row) mod ROWS
- cursor_row  out  5  logical cursor row, 0..29
- cursor_col  out  7  cursor column, 0..69
- busy  out  1  high in CLR_LINE or CLR_ALL

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- State after reset:
  - State = CLR_ALL; vm_we=0, vm_waddr=0, vm_wdata=0, top_row=0, cursor=(0,0), ch_ready=0.
  - Reset in any state (including mid-clear) aborts the current operation and restarts CLR_ALL.
- States: CLR_ALL, IDLE, CLR_LINE.
- All vmem outputs are registered. phys_row = cursor_row + top_row, minus 30 when the sum is >= 30 (never reaches 30 or 31).
- ch_ready = (state==IDLE) && !clear_req. clear_req wins over ch_valid in the same cycle.
- CLR_ALL:
  - Writes BLANK to all 2100 cells: physical row 0..29 outer, col 0..69 inner.
  - One write per cycle; first write one cycle after entry.
  - On the last write: top_row=0, cursor=(0,0), next state IDLE, ch_ready high the following cycle.
  - clear_req sampled in IDLE at cycle N gives writes at N+1..N+2100 and ready at N+2101.
- IDLE, byte accepted at cycle N, by code:
  - Printable 0x20..0x7E:
    - vm_we=1 at N+1 with vm_waddr={cursor_col, phys_row} and vm_wdata=ch_data.
    - col++. If col was 69: col=0 and a newline is applied.
  - 0x0A (LF):
    - col=0.
    - If row<29: row++, no write.
    - If row==29 (scroll): row stays 29, top_row=(top_row+1) mod 30, then CLR_LINE clears physical row = old top_row.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS):
    - If col>0: col--, then write BLANK at the new position.
    - If col==0 and row>0: row--, col=69, then write BLANK there.
    - At (0,0): no-op, no write.
  - Any other code: accepted and discarded, no write, cursor unchanged.
  - No state change and no write when no handshake occurs.
- Scroll timing:
  - LF at bottom, accepted at N: clear writes at N+1..N+70 (cols 0..69). ch_ready low N+1..N+70, high N+71.
  - Printable at (29,69), accepted at N: char write at N+1 on the old bottom row. top_row advances. Clear writes N+2..N+71; ready high at N+72.
  - cursor_row/cursor_col/top_row update in the cycle after acceptance (N+1).
- Throughput: back-to-back printable bytes accepted every cycle while in IDLE; one write per cycle.
- clear_req is ignored while in CLR_LINE and sampled again on return to IDLE.

Decomposition:
- Shared package text_term_pkg holds:
  - COLS, ROWS, COL_W, ROW_W, BLANK
  - ASCII constants LF, CR, BS
  - State enum {CLR_ALL, IDLE, CLR_LINE}
  - VMEM_AW=12
- One sub-module, term_row_map: combinational mod-ROWS adder mapping (logical row, top_row) to the physical row. It is shared by the writer here and by the scanout.

Test Plan:
- Reset release -> 2100 writes of 0x20 on consecutive cycles, first addr {0,0}, last addr {69,29}; then ch_ready=1, cursor (0,0), top_row=0.
- Send "AB" back-to-back -> writes 0x41 @ {0,0} and 0x42 @ {1,0} on consecutive cycles; cursor_col=2.
- Send 70 'x' then 'y' -> 'y' written at {0,1}; cursor (1,1); no clear burst.
- Fill to row 29, send LF -> top_row 0->1; 70 writes of 0x20 to phys row 0; ch_ready low exactly 70 cycles; cursor (29,0). Next 'z' is written at {0,0}.
- BS sequences:
  - At (0,0): no write.
  - At (3,0): BLANK written at {69, phys(2)}, cursor (2,69).
  - At (3,5): BLANK written at {4, phys(3)}, cursor (3,4).
- clear_req and ch_valid asserted in the same cycle -> byte not accepted, CLR_ALL runs. Assert rst at CLR_ALL write 500 -> restart from addr {0,0}.
